// File: rtl/button_scanner_if.sv
// rtl/button_scanner_if.sv - button state/event bundle between scanner and consumers
//
// Purpose: groups the debounced button state, press/release pulses, sticky
// press flags, their acknowledge and the scan-commit strobe.
// Ports (signals):
//   buttons   N_BITS  debounced state, 1 = pressed
//   pressed   N_BITS  one-cycle pulse on each 0->1 stable transition
//   released  N_BITS  one-cycle pulse on each 1->0 stable transition
//   press_evt N_BITS  sticky press flags
//   evt_ack   N_BITS  clears matching press_evt bits
//   scan_done 1       one-cycle pulse when a scan commits
// Modports: master = scanner, slave = button consumer.
interface button_scanner_if #(
  parameter int N_BITS = 16
) ();
  logic [N_BITS-1:0] buttons;
  logic [N_BITS-1:0] pressed;
  logic [N_BITS-1:0] released;
  logic [N_BITS-1:0] press_evt;
  logic [N_BITS-1:0] evt_ack;
  logic              scan_done;

  modport master (
    output buttons, pressed, released, press_evt, scan_done,
    input  evt_ack
  );

  modport slave (
    input  buttons, pressed, released, press_evt, scan_done,
    output evt_ack
  );
endinterface

// File: rtl/button_scanner.sv
// rtl/button_scanner.sv - debounced scanner for a parallel-in/serial-out button chain
//
// Purpose: continuously loads and shifts out a 165-style shift-register
// chain, debounces every bit and reports stable state plus events.
// Ports:
//   clk      in   system clock (CLOCK_50)
//   rst_n    in   synchronous active-low reset
//   sr_clk   out  shift clock to the chain (registered)
//   sr_loadn out  parallel-load strobe, active-low (registered)
//   sr_out   in   serial data from the chain, MSB first
//   bus      button_scanner_if.master: buttons/pressed/released/press_evt/
//            evt_ack/scan_done
// Build option: define BUTTON_SCANNER_EVENTS_EN to generate pressed,
// released and press_evt; otherwise they read 0 and evt_ack is ignored.
module button_scanner #(
  parameter int N_BITS         = 16,
  parameter int CLK_DIV        = 25,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                sr_clk,
  output logic                sr_loadn,
  input  logic                sr_out,
  button_scanner_if.master    bus
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [1:0]        state_q, state_d;
  logic              phase_q, phase_d;   // 0 = first half (loadn low / sr_clk low)
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              armed_q;
  logic              div_last;
  logic              sample_en;
  logic [N_BITS-1:0] raw_q;
  logic [N_BITS-1:0] sense;
  logic [N_BITS-1:0] buttons_q, buttons_d;
  logic [CNT_W-1:0]  cnt_q [N_BITS];
  logic [CNT_W-1:0]  cnt_d [N_BITS];
  logic              sr_clk_q, sr_loadn_q, scan_done_q;

  assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
  assign sample_en = armed_q && (state_q == ST_SHIFT) && !phase_q && div_last;

  // armed_q holds the FSM in its LOAD start position for the first edge
  // after reset so the registered strobes line up with cycle 0 of LOAD.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    idx_d   = idx_q;
    if (armed_q) begin
      div_d = div_last ? '0 : div_q + DIV_W'(1);
      case (state_q)
        ST_LOAD: begin
          if (div_last) begin
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              state_d = ST_SHIFT;
              phase_d = 1'b0;
              idx_d   = IDX_W'(N_BITS - 1);
            end
          end
        end
        ST_SHIFT: begin
          if (div_last) begin
            if (!phase_q) begin
              phase_d = 1'b1;
            end else if (idx_q == '0) begin
              state_d = ST_COMMIT;
              phase_d = 1'b0;
            end else begin
              idx_d   = idx_q - IDX_W'(1);
              phase_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_LOAD;
          phase_d = 1'b0;
          div_d   = '0;
        end
      endcase
    end
  end

  assign sense = (ACTIVE_LOW != 0) ? ~raw_q : raw_q;

  always_comb begin
    buttons_d = buttons_q;
    for (int i = 0; i < N_BITS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (state_q == ST_COMMIT) begin
      for (int i = 0; i < N_BITS; i++) begin
        if (sense[i] == buttons_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
          buttons_d[i] = ~buttons_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      phase_q     <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      armed_q     <= 1'b0;
      raw_q       <= '0;
      buttons_q   <= '0;
      sr_clk_q    <= 1'b0;
      sr_loadn_q  <= 1'b1;
      scan_done_q <= 1'b0;
      for (int i = 0; i < N_BITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      armed_q     <= 1'b1;
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      // strobes are decoded from the next state so they are valid in the
      // same cycle as the state they belong to
      sr_loadn_q  <= !((state_d == ST_LOAD) && !phase_d);
      sr_clk_q    <= (state_d == ST_SHIFT) && phase_d;
      scan_done_q <= (state_d == ST_COMMIT);
      if (sample_en) begin
        raw_q[idx_q] <= sr_out;
      end
      buttons_q <= buttons_d;
      for (int i = 0; i < N_BITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sr_clk        = sr_clk_q;
  assign sr_loadn      = sr_loadn_q;
  assign bus.buttons   = buttons_q;
  assign bus.scan_done = scan_done_q;

`ifdef BUTTON_SCANNER_EVENTS_EN
  logic [N_BITS-1:0] pressed_q, released_q, press_evt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_q   <= '0;
      released_q  <= '0;
      press_evt_q <= '0;
    end else begin
      pressed_q   <= (state_q == ST_COMMIT) ? (buttons_d & ~buttons_q) : '0;
      released_q  <= (state_q == ST_COMMIT) ? (~buttons_d & buttons_q) : '0;
      // a new press wins over a simultaneous acknowledge
      press_evt_q <= (press_evt_q & ~bus.evt_ack) | pressed_q;
    end
  end

  assign bus.pressed   = pressed_q;
  assign bus.released  = released_q;
  assign bus.press_evt = press_evt_q;
`else
  logic unused_evt_ack;
  assign unused_evt_ack = ^bus.evt_ack;
  assign bus.pressed    = '0;
  assign bus.released   = '0;
  assign bus.press_evt  = '0;
`endif

endmodule

// File: tb/tb_button_scanner.sv
// tb/tb_button_scanner.sv - directed self-checking bench for button_scanner
module tb_button_scanner;
  localparam int N   = 16;
  localparam int DIV = 2;
  localparam int DEB = 3;
`ifdef BUTTON_SCANNER_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sr_clk, sr_loadn, sr_out;

  button_scanner_if #(.N_BITS(N)) bus ();

  button_scanner #(
    .N_BITS(N), .CLK_DIV(DIV), .DEBOUNCE_SCANS(DEB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sr_clk(sr_clk), .sr_loadn(sr_loadn),
    .sr_out(sr_out), .bus(bus)
  );

  always #10 clk = ~clk;

  // 165-style chain: press_set bit = 1 drives the pin low
  logic [N-1:0] press_set = '0;
  logic [N-1:0] sreg = '1;
  logic         prev_sr_clk = 1'b0;
  always @(posedge clk) begin
    prev_sr_clk <= sr_clk;
    if (!sr_loadn) sreg <= ~press_set;
    else if (sr_clk && !prev_sr_clk) sreg <= {sreg[N-2:0], 1'b1};
  end
  assign sr_out = sreg[N-1];

  int checks = 0;
  int failures = 0;
  int press5_cnt = 0;

  always @(negedge clk) if (bus.pressed[5]) press5_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_commit(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.scan_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.scan_done !== 1'b1) check_val({tag, "_timeout"}, 32'(bus.scan_done), 32'd1);
  endtask

  // one full scan with the given chain contents; returns on the cycle after COMMIT
  task automatic scan(input logic [N-1:0] ps);
    press_set = ps;
    wait_commit("scan");
    @(negedge clk);
  endtask

  logic [N-1:0] bounce_pat [6] = '{16'h0021, 16'h0021, 16'h0001, 16'h0021, 16'h0021, 16'h0021};
  logic         bounce_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int first_rise, sd1, sd2, bad_btn;
    bus.evt_ack = '0;
    press_set = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_loadn", 32'(sr_loadn), 32'd1);
    check_val("rst_srclk", 32'(sr_clk), 32'd0);
    check_val("rst_buttons", 32'(bus.buttons), 32'h0);
    check_val("rst_scan_done", 32'(bus.scan_done), 32'd0);
    check_val("rst_press_evt", 32'(bus.press_evt), 32'h0);

    // reset release: cycle k is sampled at the k-th negedge after release
    rst_n = 1'b1;
    first_rise = -1; sd1 = -1; sd2 = -1; bad_btn = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k < 2) check_val($sformatf("loadn_low_c%0d", k), 32'(sr_loadn), 32'd0);
      else if (k < 4) check_val($sformatf("loadn_high_c%0d", k), 32'(sr_loadn), 32'd1);
      if (sr_clk && first_rise < 0) first_rise = k;
      if (bus.scan_done) begin
        if (sd1 < 0) sd1 = k;
        else if (sd2 < 0) sd2 = k;
      end
      if (bus.buttons != '0) bad_btn++;
    end
    check_val("first_srclk_rise", 32'(first_rise), 32'd6);
    check_val("first_scan_done", 32'(sd1), 32'd68);
    check_val("second_scan_done", 32'(sd2), 32'd137);
    check_val("idle_buttons_nonzero", 32'(bad_btn), 32'd0);

    // bit 0 held pressed: flips on the 3rd commit
    wait_commit("sync");
    scan(16'h0001);
    check_val("p0_scan1_buttons", 32'(bus.buttons), 32'h0);
    scan(16'h0001);
    check_val("p0_scan2_buttons", 32'(bus.buttons), 32'h0);
    scan(16'h0001);
    check_val("p0_scan3_buttons", 32'(bus.buttons), 32'h0001);
    check_val("p0_pressed", 32'(bus.pressed), EV ? 32'h0001 : 32'h0);
    @(negedge clk);
    check_val("p0_pressed_gone", 32'(bus.pressed), 32'h0);
    check_val("p0_evt_set", 32'(bus.press_evt), EV ? 32'h0001 : 32'h0);
    repeat (100) @(negedge clk);
    check_val("p0_evt_sticky", 32'(bus.press_evt), EV ? 32'h0001 : 32'h0);
    bus.evt_ack = 16'h0001;
    @(negedge clk);
    bus.evt_ack = '0;
    check_val("p0_evt_acked", 32'(bus.press_evt), 32'h0);

    // bit 5 bounces: only the 6th scan completes three agreeing scans
    wait_commit("sync2");
    @(negedge clk);
    press5_cnt = 0;
    for (int s = 0; s < 6; s++) begin
      scan(bounce_pat[s]);
      check_val($sformatf("b5_scan%0d", s + 1), 32'(bus.buttons[5]), 32'(bounce_exp[s]));
    end
    @(negedge clk);
    check_val("b5_press_pulses", 32'(press5_cnt), EV ? 32'd1 : 32'd0);

    // stable press of bit 15, then release
    repeat (3) scan(16'h8021);
    check_val("b15_buttons", 32'(bus.buttons), 32'h8021);
    scan(16'h0021);
    check_val("b15_rel_scan1", 32'(bus.released), 32'h0);
    scan(16'h0021);
    check_val("b15_rel_scan2", 32'(bus.released), 32'h0);
    scan(16'h0021);
    check_val("b15_released", 32'(bus.released), EV ? 32'h8000 : 32'h0);
    check_val("b15_buttons_after", 32'(bus.buttons), 32'h0021);

    // acknowledge coinciding with a new press of bit 3
    repeat (3) scan(16'h0029);
    check_val("b3_pressed", 32'(bus.pressed), EV ? 32'h0008 : 32'h0);
    bus.evt_ack = 16'h0008;
    @(negedge clk);
    bus.evt_ack = '0;
    check_val("b3_set_wins", 32'(bus.press_evt[3]), EV ? 32'd1 : 32'd0);
    bus.evt_ack = 16'h0008;
    @(negedge clk);
    bus.evt_ack = '0;
    check_val("b3_acked", 32'(bus.press_evt[3]), 32'd0);

    // reset during SHIFT of bit index 7 (cycles 36..39 of the scan)
    wait_commit("sync3");
    @(negedge clk);
    repeat (37) @(negedge clk);
    check_val("pre_rst_buttons", 32'(bus.buttons), 32'h0029);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_srclk", 32'(sr_clk), 32'd0);
    check_val("mid_rst_loadn", 32'(sr_loadn), 32'd1);
    check_val("mid_rst_buttons", 32'(bus.buttons), 32'h0);
    check_val("mid_rst_pressed", 32'(bus.pressed), 32'h0);
    check_val("mid_rst_released", 32'(bus.released), 32'h0);
    check_val("mid_rst_press_evt", 32'(bus.press_evt), 32'h0);
    check_val("mid_rst_scan_done", 32'(bus.scan_done), 32'd0);
    rst_n = 1'b1;
    sd1 = -1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0) check_val("restart_loadn", 32'(sr_loadn), 32'd0);
      if (bus.scan_done && sd1 < 0) sd1 = k;
      if (k == 69) begin
        check_val("restart_buttons", 32'(bus.buttons), 32'h0);
        check_val("restart_released", 32'(bus.released), 32'h0);
      end
    end
    check_val("restart_scan_done", 32'(sd1), 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/button_scanner.md
# button_scanner

Parametrised scanner for the display board's parallel-in/serial-out button shift-register chain. It is the successor to the fixed 16-bit controller and scales to any chain length and shift-clock rate. It adds per-bit debouncing, single-cycle press/release pulses and sticky, acknowledgeable event flags. It sits between the `SHIFT_CLKIN`/`SHIFT_LOAD`/`SHIFT_OUT` pins and the button consumers in the toplevel.

## Interface
- `N_BITS`, default 16: number of bits in the chain; must be ≥ 1.
- `CLK_DIV`, default 25: shift-clock half-period in `clk` cycles; must be ≥ 1. At 50 MHz the default gives 1 MHz.
- `DEBOUNCE_SCANS`, default 4: consecutive disagreeing scans needed to flip a stable bit; must be ≥ 1.
- `ACTIVE_LOW`, default 1: when 1, a sampled 0 means pressed.
- `clk` input 1: system clock (`CLOCK_50`).
- `rst_n` input 1: reset. One clock; reset is synchronous and active-low.
- `sr_clk` output 1: shift clock to the chain.
- `sr_loadn` output 1: parallel-load strobe, active-low.
- `sr_out` input 1: serial data from the chain.
- `buttons` output N_BITS: debounced state, 1 = pressed.
- `pressed` output N_BITS: one-cycle pulse on each 0→1 stable transition.
- `released` output N_BITS: one-cycle pulse on each 1→0 stable transition.
- `press_evt` output N_BITS: sticky press flags.
- `evt_ack` input N_BITS: clears the matching `press_evt` bits.
- `scan_done` output 1: one-cycle pulse when a scan commits.

## Operation
- **Reset values.** While `rst_n` = 0 at a rising edge, the block resets:
  - `sr_clk` = 0 and `sr_loadn` = 1.
  - `buttons`, `pressed`, `released`, `press_evt` and `scan_done` = 0.
  - All debounce counters = 0 and the FSM = LOAD.
- **FSM states: LOAD → SHIFT → COMMIT → LOAD.** The block scans continuously.
- **LOAD.**
  - `sr_loadn` = 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles (settle).
  - `sr_clk` stays 0. Then go to SHIFT with the bit index at N_BITS-1.
- **SHIFT.** Each bit takes 2·CLK_DIV cycles:
  - `sr_clk` = 0 for CLK_DIV cycles; `sr_out` is sampled on the last of these into `raw[index]`.
  - `sr_clk` = 1 for CLK_DIV cycles; that rising edge advances the chain.
  - The first sample is the MSB. After index 0, go to COMMIT.
- **COMMIT** lasts one cycle.
  - `scan_done` = 1.
  - Each bit computes `s = raw ^ ACTIVE_LOW`.
  - If `s == buttons[i]`, its counter is cleared to 0. Otherwise the counter increments.
  - When the increment would reach DEBOUNCE_SCANS, `buttons[i]` toggles and the counter clears.
- **Pulses.** `pressed[i]` / `released[i]` are high for exactly the one cycle after COMMIT, which is when the new `buttons[i]` first becomes visible. They are 0 otherwise.
- **Event flags.** `press_evt[i]` is set on `pressed[i]` and cleared by `evt_ack[i]`. If set and ack coincide, set wins.
- **Counter width.** Debounce counters are `$clog2(DEBOUNCE_SCANS+1)` bits. With DEBOUNCE_SCANS = 1, a single disagreeing scan flips the bit.
- **Divider.** The divider counter is `$clog2(CLK_DIV)` bits (minimum 1). It wraps to 0 at CLK_DIV-1.
- **Reset mid-scan.** Reset aborts the scan and discards any partial `raw`. Scanning restarts at LOAD on the first cycle after `rst_n` returns to 1.

## Timing
- **Scan period** is (N_BITS+1)·2·CLK_DIV + 1 cycles. The defaults give 851 cycles (17.02 µs).
- **Sampling point.** `sr_out` is sampled CLK_DIV cycles after `sr_clk` falls, or after `sr_loadn` rises for the first bit.
- **`sr_clk`/`sr_loadn`** are registered outputs with no combinational path from the inputs.
- **Latency.** The first `scan_done` comes (N_BITS+1)·2·CLK_DIV cycles after reset release. A press that is stable on the pins is reflected in `buttons` DEBOUNCE_SCANS scans later, one cycle after that scan's COMMIT.
- **`evt_ack`** takes effect on the next edge; the flag reads 0 the following cycle.

## Configuration
- **`BUTTON_SCANNER_EVENTS_EN` defined:** `pressed`, `released` and `press_evt` are generated as described above.
- **Undefined:**
  - Those three outputs are tied to 0, `evt_ack` is ignored and no event registers are synthesised.
  - `buttons`, `scan_done` and the shift timing are unchanged.

## Test plan
Bench parameters: N_BITS = 16, CLK_DIV = 2, DEBOUNCE_SCANS = 3, ACTIVE_LOW = 1, with a 165-style chain model.
- **Reset, then release.** Required response:
  - `sr_loadn` is low during cycles 0–1 and high during 2–3.
  - The first `sr_clk` rise is at cycle 6.
  - `scan_done` pulses at cycle 68, then every 69 cycles.
  - `buttons` stays 0x0000.
- **Hold chain = 0xFFFE** (bit 0 pressed, active-low). Required response:
  - `buttons` becomes 0x0001 on the cycle after the 3rd COMMIT.
  - `pressed` = 0x0001 for exactly that cycle.
  - `press_evt` = 0x0001 until `evt_ack` = 0x0001.
- **Bit 5 bounces** (pressed in scans 1 and 2, released in 3, pressed in 4–6). Required response: `buttons[5]` rises only after scan 6, and there is one `pressed` pulse.
- **Release after a stable press of 0x8000.** Required response: `released` = 0x8000 three scans after the release.
- **Ack coincides with a new press of the same bit.** Required response: `press_evt` stays 1.
- **Assert `rst_n` during SHIFT at bit index 7.** Required response: all outputs read their reset values on the next cycle, and the next scan restarts at LOAD with no partial commit.
